// File: rtl/tdm_demux_1to4_if.sv
// Bundle of link-side and consumer-side signals for the 1:4 TDM demultiplexer.
// The master side drives the serial link and observes the frame; the slave side is the demux.
interface tdm_demux_1to4_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0]   din;
    logic               din_valid;
    logic               frame_sync;
    logic [4*WIDTH-1:0] dout;
    logic               dout_valid;
    logic [1:0]         slot;
    logic               locked;
    logic               sync_err;

    modport master (
        output din,
        output din_valid,
        output frame_sync,
        input  dout,
        input  dout_valid,
        input  slot,
        input  locked,
        input  sync_err
    );

    modport slave (
        input  din,
        input  din_valid,
        input  frame_sync,
        output dout,
        output dout_valid,
        output slot,
        output locked,
        output sync_err
    );
endinterface

// File: rtl/tdm_demux_1to4.sv
// Receive end of a 4-channel TDM link: aligns to the frame marker, collects slots 0..2
// into shadow lanes and publishes the whole frame atomically when slot 3 arrives.
module tdm_demux_1to4 #(
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    tdm_demux_1to4_if.slave       bus
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                     state_q, state_d;
    logic [1:0]                 slot_q, slot_d;
    logic [2:0][WIDTH-1:0]      shadow_q, shadow_d;
    logic [4*WIDTH-1:0]         dout_q, dout_d;
    logic                       dout_valid_q, dout_valid_d;
    logic                       sync_err_q, sync_err_d;

    // Next-state: steer each accepted sample to its lane; slot 3 publishes the frame,
    // a marker arriving mid-frame throws the partial frame away and restarts at lane 0.
    always_comb begin
        state_d      = state_q;
        slot_d       = slot_q;
        shadow_d     = shadow_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        sync_err_d   = 1'b0;

        if (bus.din_valid) begin
            if (state_q == HUNT) begin
                if (bus.frame_sync) begin
                    shadow_d[0] = bus.din;
                    slot_d      = 2'd1;
                    state_d     = LOCKED;
                end
            end else if (bus.frame_sync) begin
                sync_err_d  = (slot_q != 2'd0);
                shadow_d[0] = bus.din;
                slot_d      = 2'd1;
            end else begin
                case (slot_q)
                    2'd0: begin
                        shadow_d[0] = bus.din;
                        slot_d      = 2'd1;
                    end
                    2'd1: begin
                        shadow_d[1] = bus.din;
                        slot_d      = 2'd2;
                    end
                    2'd2: begin
                        shadow_d[2] = bus.din;
                        slot_d      = 2'd3;
                    end
                    default: begin
                        dout_d       = {bus.din, shadow_q};
                        dout_valid_d = 1'b1;
                        slot_d       = 2'd0;
                    end
                endcase
            end
        end
    end

    // State, lane and output registers; reset returns everything to an empty, hunting receiver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= HUNT;
            slot_q       <= 2'd0;
            shadow_q     <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            slot_q       <= slot_d;
            shadow_q     <= shadow_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.slot       = slot_q;
    assign bus.locked     = (state_q == LOCKED);
    assign bus.sync_err   = sync_err_q;

endmodule

// File: tb/tb_tdm_demux_1to4.sv
// Scoreboard bench for tdm_demux_1to4: a narrow (WIDTH=1) and a wide (WIDTH=8) instance,
// expected frames queued at stimulus time and popped by per-instance monitors.
module tb_tdm_demux_1to4;

    logic clk;
    logic rst;

    int n_compared;
    int n_mismatched;

    logic [3:0]  exp_q1[$];
    logic [31:0] exp_q8[$];

    tdm_demux_1to4_if #(.WIDTH(1)) bus1 ();
    tdm_demux_1to4_if #(.WIDTH(8)) bus8 ();

    tdm_demux_1to4 #(.WIDTH(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    tdm_demux_1to4 #(.WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the run always ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Narrow instance: one sample per cycle, outputs sampled 1 ns after the edge
    task automatic applyStimulus(input logic v, input logic s, input logic d);
        @(negedge clk);
        bus1.din_valid  = v;
        bus1.frame_sync = s;
        bus1.din        = d;
        @(posedge clk);
        #1;
    endtask

    task automatic applyWide(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        bus8.din_valid  = v;
        bus8.frame_sync = s;
        bus8.din        = d;
        @(posedge clk);
        #1;
    endtask

    // Monitor for the narrow instance: every dout_valid must match a queued frame
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus1.dout_valid === 1'b1) begin
                if (exp_q1.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL w1_unexpected_frame: actual=%0h required=no_frame", bus1.dout);
                end else begin
                    checkOutput("w1_frame", {28'd0, bus1.dout}, {28'd0, exp_q1.pop_front()});
                end
            end
        end
    end

    // Monitor for the wide instance
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (bus8.dout_valid === 1'b1) begin
                if (exp_q8.size() == 0) begin
                    n_compared++;
                    n_mismatched++;
                    $display("[TB] FAIL w8_unexpected_frame: actual=%0h required=no_frame", bus8.dout);
                end else begin
                    checkOutput("w8_frame", bus8.dout, exp_q8.pop_front());
                end
            end
        end
    end

    // Directed test sequence
    initial begin
        n_compared   = 0;
        n_mismatched = 0;
        rst             = 1'b1;
        bus1.din_valid  = 1'b0;
        bus1.frame_sync = 1'b0;
        bus1.din        = 1'b0;
        bus8.din_valid  = 1'b0;
        bus8.frame_sync = 1'b0;
        bus8.din        = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;

        // Reset state
        checkOutput("rst_dout",   {28'd0, bus1.dout}, 32'h0);
        checkOutput("rst_slot",   {30'd0, bus1.slot}, 32'h0);
        checkOutput("rst_locked", {31'd0, bus1.locked}, 32'h0);
        checkOutput("rst_valid",  {31'd0, bus1.dout_valid}, 32'h0);
        checkOutput("rst_serr",   {31'd0, bus1.sync_err}, 32'h0);

        // Lock and frame: sync+1, 1, 0, 0 -> 4'b0011, slot 1,2,3,0
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("lock_slot1", {30'd0, bus1.slot}, 32'd1);
        checkOutput("lock_locked", {31'd0, bus1.locked}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("lock_slot2", {30'd0, bus1.slot}, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lock_slot3", {30'd0, bus1.slot}, 32'd3);
        exp_q1.push_back(4'b0011);
        applyStimulus(1'b1, 1'b0, 1'b0);
        checkOutput("lock_slot0", {30'd0, bus1.slot}, 32'd0);
        checkOutput("lock_dout",  {28'd0, bus1.dout}, 32'h3);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("lock_hold_dout", {28'd0, bus1.dout}, 32'h3);

        // Reset mid-frame: two samples in, then asynchronous reset between edges
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        @(negedge clk);
        bus1.din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("arst_dout",   {28'd0, bus1.dout}, 32'h0);
        checkOutput("arst_slot",   {30'd0, bus1.slot}, 32'h0);
        checkOutput("arst_locked", {31'd0, bus1.locked}, 32'h0);
        checkOutput("arst_valid",  {31'd0, bus1.dout_valid}, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Hunt discard: three unsynced samples dropped, then 0,1,0,1 with sync -> 4'b1010
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("hunt_slot_a", {30'd0, bus1.slot}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("hunt_slot_c",   {30'd0, bus1.slot}, 32'd0);
        checkOutput("hunt_unlocked", {31'd0, bus1.locked}, 32'd0);
        applyStimulus(1'b0, 1'b1, 1'b1);
        checkOutput("hunt_sync_novalid", {31'd0, bus1.locked}, 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        checkOutput("hunt_locked", {31'd0, bus1.locked}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        exp_q1.push_back(4'b1010);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("hunt_dout", {28'd0, bus1.dout}, 32'ha);

        // Mid-frame resync: slots 0,1 then sync+1 -> sync_err, slot 1; complete 1,1,1 -> 4'b1111
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b1);
        checkOutput("resync_err",  {31'd0, bus1.sync_err}, 32'd1);
        checkOutput("resync_slot", {30'd0, bus1.slot}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("resync_err_pulse", {31'd0, bus1.sync_err}, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        exp_q1.push_back(4'b1111);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("resync_dout", {28'd0, bus1.dout}, 32'hf);

        // Gapped input: 1,0,1,1 with two idle cycles between samples -> 4'b1101
        applyStimulus(1'b1, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("gap_slot_hold1", {30'd0, bus1.slot}, 32'd1);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b1);
        checkOutput("gap_slot_hold2", {30'd0, bus1.slot}, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        checkOutput("gap_slot_hold3", {30'd0, bus1.slot}, 32'd3);
        checkOutput("gap_dout_hold", {28'd0, bus1.dout}, 32'hf);
        exp_q1.push_back(4'b1101);
        applyStimulus(1'b1, 1'b0, 1'b1);
        checkOutput("gap_dout", {28'd0, bus1.dout}, 32'hd);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Wide back-to-back frames: dout_valid only after samples 4 and 8
        begin
            logic [7:0] wide_data [8];
            logic [31:0] exp_valid;
            wide_data = '{8'hA1, 8'hB2, 8'hC3, 8'hD4, 8'h11, 8'h22, 8'h33, 8'h44};
            exp_valid = 32'd0;
            for (int i = 0; i < 8; i++) begin
                if (i == 3) exp_q8.push_back(32'hD4C3B2A1);
                if (i == 7) exp_q8.push_back(32'h44332211);
                applyWide(1'b1, (i == 0) || (i == 4), wide_data[i]);
                exp_valid = ((i == 3) || (i == 7)) ? 32'd1 : 32'd0;
                checkOutput($sformatf("w8_valid_cycle%0d", i + 1), {31'd0, bus8.dout_valid}, exp_valid);
            end
            applyWide(1'b0, 1'b0, 8'h00);
            checkOutput("w8_valid_after", {31'd0, bus8.dout_valid}, 32'd0);
            checkOutput("w8_dout_hold", bus8.dout, 32'h44332211);
        end

        // Every queued frame must have been delivered
        checkOutput("w1_queue_drained", exp_q1.size(), 32'd0);
        checkOutput("w8_queue_drained", exp_q8.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
